dmem_responder: RTL and testbench

Data-memory responder serving load/store requests issued by the pipeline's MEM stage over a valid/ready request channel and a single-cycle response pulse. It replaces the zero-latency combinational memory model with a word-organised RAM that inserts a fixed number of wait states and supports byte, halfword and word accesses with sign or zero extension. Misaligned and out-of-range accesses are rejected with an error response. The MEM stage stalls on `busy`.

---
 rtl/dmem_if.sv | 33 +++
 rtl/dmem_responder.sv | 268 ++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: load/store request channel and single-cycle response between the
// MEM stage (master) and the data-memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_write           : 1 = store, 0 = load
//   req_addr            : byte address
//   req_wdata           : right-aligned store data
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        : zero-extend loads when set
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata           : extended load data (0 for stores/errors)
//   rsp_error           : misaligned, out of range or illegal size
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM with a fixed number of wait states,
// byte/half/word accesses and sign/zero extension of loads. Misaligned,
// out-of-range and illegal-size requests get an error response.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   bus          : dmem_if.slave request/response channel
//   busy         : request accepted, response not yet delivered
//   perf_loads   : completed non-error loads, saturating (DMEM_PERF_EN only)
//   perf_stores  : completed non-error stores, saturating (DMEM_PERF_EN only)
// Optional feature macro: DMEM_PERF_EN adds the performance counters.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  dmem_if.slave       bus,
  output logic        busy
`ifdef DMEM_PERF_EN
  ,
  output logic [15:0] perf_loads,
  output logic [15:0] perf_stores
`endif
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned LW = AW + 2;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  // Illegal size, misalignment or word index beyond the RAM.
  function automatic logic addr_err(input logic [31:0] a, input logic [1:0] s);
    logic [31:0] widx;
    widx = {2'b00, a[31:2]};
    return (s == 2'b11) ||
           ((s == 2'b01) && a[0]) ||
           ((s == 2'b10) && (a[1:0] != 2'b00)) ||
           (widx >= 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] lane, input logic [1:0] s);
    logic [3:0] be;
    case (s)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the right-aligned store data across every lane.
  function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [1:0] s);
    logic [31:0] r;
    case (s)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Shift the addressed lane down and extend to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lane,
                                           input logic [1:0] s, input logic uns);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {lane, 3'b000};
    case (s)
      2'b00:   r = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   r = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [LW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            err_q, err_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            rsp_error_q, rsp_error_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            req_err_c;
  logic            from_req_c;
  logic            acc_write_c;
  logic [LW-1:0]   acc_addr_c;
  logic [31:0]     acc_wdata_c;
  logic [1:0]      acc_size_c;
  logic            acc_uns_c;
  logic [AW-1:0]   acc_idx_c;
  logic            do_acc_c;
  logic            mem_we_c;
  logic [3:0]      mem_be_c;
  logic [31:0]     mem_wdata_c;

  assign req_err_c = addr_err(bus.req_addr, bus.req_size);

  // With zero wait states the access uses the request being accepted.
  assign from_req_c  = (state_q == S_IDLE);
  assign acc_write_c = from_req_c ? bus.req_write           : write_q;
  assign acc_addr_c  = from_req_c ? bus.req_addr[LW-1:0]    : addr_q;
  assign acc_wdata_c = from_req_c ? bus.req_wdata           : wdata_q;
  assign acc_size_c  = from_req_c ? bus.req_size            : size_q;
  assign acc_uns_c   = from_req_c ? bus.req_unsigned        : uns_q;
  assign acc_idx_c   = acc_addr_c[LW-1:2];

`ifdef DMEM_PERF_EN
  logic [15:0] perf_loads_q, perf_loads_d;
  logic [15:0] perf_stores_q, perf_stores_d;
`endif

  // Next-state, access and response computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    uns_d       = uns_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_error_d = 1'b0;
    do_acc_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_be_c    = 4'h0;
    mem_wdata_c = 32'h0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr[LW-1:0];
          wdata_d = bus.req_wdata;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          err_d   = req_err_c;
          // Errors always spend one cycle in WAIT so their latency is fixed at 2.
          if ((WAIT_STATES == 0) && !req_err_c) begin
            do_acc_c = 1'b1;
            state_d  = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = (WAIT_STATES == 0) ? CW'(0) : CW'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (err_q) begin
          rsp_error_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == CW'(0)) begin
          do_acc_c = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d = (state_d == S_RESP) && (state_q != S_RESP);

    if (do_acc_c) begin
      if (acc_write_c) begin
        mem_we_c    = 1'b1;
        mem_be_c    = byte_en(acc_addr_c[1:0], acc_size_c);
        mem_wdata_c = store_lanes(acc_wdata_c, acc_size_c);
      end else begin
        rsp_rdata_d = load_ext(mem[acc_idx_c], acc_addr_c[1:0], acc_size_c, acc_uns_c);
      end
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);

`ifdef DMEM_PERF_EN
    perf_loads_d  = perf_loads_q;
    perf_stores_d = perf_stores_q;
    if ((state_q == S_RESP) && !rsp_error_q) begin
      if (write_q) begin
        if (perf_stores_q != 16'hFFFF) perf_stores_d = perf_stores_q + 16'd1;
      end else begin
        if (perf_loads_q != 16'hFFFF) perf_loads_d = perf_loads_q + 16'd1;
      end
    end
`endif
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  // RAM array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be_c[b]) mem[acc_idx_c][8*b +: 8] <= mem_wdata_c[8*b +: 8];
      end
    end
  end

`ifdef DMEM_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_loads_q  <= 16'h0;
      perf_stores_q <= 16'h0;
    end else begin
      perf_loads_q  <= perf_loads_d;
      perf_stores_q <= perf_stores_d;
    end
  end

  assign perf_loads  = perf_loads_q;
  assign perf_stores = perf_stores_q;
`endif

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: table of load/store vectors with a response
// scoreboard, plus reset-abort and back-to-back sequences.
module tb_dmem_responder;
  localparam int unsigned WS    = 2;
  localparam int unsigned DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   n_loads = 0;
  int   n_stores = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_if bus();

`ifdef DMEM_PERF_EN
  logic [15:0] perf_loads;
  logic [15:0] perf_stores;
`endif

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .busy  (busy)
`ifdef DMEM_PERF_EN
    ,
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores)
`endif
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        wr;
    int          cyc;
    int          idx;
  } exp_t;

  exp_t sb[$];

  function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard on every response pulse.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk($sformatf("rsp_rdata[%0d]", e.idx), bus.rsp_rdata, e.rdata);
          chk($sformatf("rsp_error[%0d]", e.idx), 32'(bus.rsp_error), 32'(e.err));
          chk($sformatf("rsp_cycle[%0d]", e.idx), 32'(cyc), 32'(e.cyc));
          if (!e.err) begin
            if (e.wr) n_stores++;
            else      n_loads++;
          end
        end
      end else if (bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
        tests++;
        fails++;
        $display("FAIL idle_rsp_fields: got err=%b rdata=%h expected 0 outside rsp_valid",
                 bus.rsp_error, bus.rsp_rdata);
      end
    end
  end

  // Present a request and wait for its acceptance; returns at the negedge after it.
  task automatic issue(input vec_t v, input int idx, output int acc_edge, output int lowcnt);
    int   n;
    exp_t e;
    bus.req_valid    = 1'b1;
    bus.req_write    = v.wr;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    lowcnt = 0;
    n      = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      lowcnt++;
      n++;
    end
    if (!bus.req_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout[%0d]: got req_ready=0 expected 1 within 50 cycles", idx);
      acc_edge      = -1;
      bus.req_valid = 1'b0;
      return;
    end
    acc_edge = cyc + 1;
    e.rdata  = v.exp_rdata;
    e.err    = v.exp_err;
    e.wr     = v.wr;
    e.idx    = idx;
    e.cyc    = acc_edge + (v.exp_err ? 2 : int'(WS) + 1) - 1;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run_one(input vec_t v, input int idx);
    int a;
    int l;
    issue(v, idx, a, l);
    bus.req_valid = 1'b0;
    drain();
  endtask

  vec_t tbl[18];
  vec_t b2b[5];

  initial begin
    int acc_prev;
    int acc;
    int low;

    tbl[0]  = mk(1'b1, 32'h40,   32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b0); // sw
    tbl[1]  = mk(1'b0, 32'h40,   32'h0,        2'b10, 1'b0, 32'hDEADBEEF, 1'b0); // lw
    tbl[2]  = mk(1'b0, 32'h43,   32'h0,        2'b00, 1'b0, 32'hFFFFFFDE, 1'b0); // lb
    tbl[3]  = mk(1'b0, 32'h43,   32'h0,        2'b00, 1'b1, 32'h000000DE, 1'b0); // lbu
    tbl[4]  = mk(1'b0, 32'h40,   32'h0,        2'b01, 1'b0, 32'hFFFFBEEF, 1'b0); // lh
    tbl[5]  = mk(1'b0, 32'h42,   32'h0,        2'b01, 1'b1, 32'h0000DEAD, 1'b0); // lhu
    tbl[6]  = mk(1'b1, 32'h41,   32'h0000005A, 2'b00, 1'b0, 32'h0,        1'b0); // sb
    tbl[7]  = mk(1'b0, 32'h40,   32'h0,        2'b10, 1'b0, 32'hDEAD5AEF, 1'b0); // lw
    tbl[8]  = mk(1'b0, 32'h42,   32'h0,        2'b10, 1'b0, 32'h0,        1'b1); // misaligned lw
    tbl[9]  = mk(1'b1, 32'h0,    32'h12345678, 2'b10, 1'b0, 32'h0,        1'b0); // sw word 0
    tbl[10] = mk(1'b1, 32'(DEPTH*4), 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0,    1'b1); // out of range
    tbl[11] = mk(1'b0, 32'h0,    32'h0,        2'b10, 1'b0, 32'h12345678, 1'b0); // word 0 unchanged
    tbl[12] = mk(1'b0, 32'h40,   32'h0,        2'b11, 1'b0, 32'h0,        1'b1); // illegal size
    tbl[13] = mk(1'b0, 32'h41,   32'h0,        2'b01, 1'b0, 32'h0,        1'b1); // misaligned lh
    tbl[14] = mk(1'b1, 32'h42,   32'hFFFF8123, 2'b01, 1'b0, 32'h0,        1'b0); // sh upper half
    tbl[15] = mk(1'b0, 32'h40,   32'h0,        2'b10, 1'b0, 32'h81235AEF, 1'b0); // lw
    tbl[16] = mk(1'b0, 32'h42,   32'h0,        2'b01, 1'b0, 32'hFFFF8123, 1'b0); // lh upper
    tbl[17] = mk(1'b0, 32'h41,   32'h0,        2'b00, 1'b0, 32'h0000005A, 1'b0); // lb positive

    b2b[0] = mk(1'b1, 32'h80, 32'h01020304, 2'b10, 1'b0, 32'h0,        1'b0);
    b2b[1] = mk(1'b0, 32'h80, 32'h0,        2'b10, 1'b0, 32'h01020304, 1'b0);
    b2b[2] = mk(1'b1, 32'h82, 32'h0000BEEF, 2'b01, 1'b0, 32'h0,        1'b0);
    b2b[3] = mk(1'b0, 32'h83, 32'h0,        2'b00, 1'b1, 32'h000000BE, 1'b0);
    b2b[4] = mk(1'b0, 32'h82, 32'h0,        2'b01, 1'b0, 32'hFFFFBEEF, 1'b0);

    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_error", 32'(bus.rsp_error), 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h1);

    // Reset mid-WAIT drops an uncommitted store.
    run_one(mk(1'b1, 32'h10, 32'h11223344, 2'b10, 1'b0, 32'h0, 1'b0), 100);
    issue(mk(1'b1, 32'h10, 32'hAAAAAAAA, 2'b10, 1'b0, 32'h0, 1'b0), 101, acc, low);
    bus.req_valid = 1'b0;
    chk("abort_busy_before", 32'(busy), 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("abort_rsp_error", 32'(bus.rsp_error), 32'h0);
    chk("abort_rsp_rdata", bus.rsp_rdata, 32'h0);
    sb.delete();
    n_loads  = 0;
    n_stores = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_req_ready", 32'(bus.req_ready), 32'h1);
    run_one(mk(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h11223344, 1'b0), 102);

    // Table of single transactions.
    for (int i = 0; i < 18; i++) run_one(tbl[i], i);

    // Back-to-back with req_valid held high.
    acc_prev = -1;
    for (int i = 0; i < 5; i++) begin
      issue(b2b[i], 200 + i, acc, low);
      if (i > 0) begin
        chk($sformatf("b2b_spacing[%0d]", i), 32'(acc - acc_prev), 32'(WS + 2));
        chk($sformatf("b2b_ready_low[%0d]", i), 32'(low), 32'(WS + 1));
      end
      acc_prev = acc;
    end
    bus.req_valid = 1'b0;
    drain();
    @(negedge clk);

`ifdef DMEM_PERF_EN
    chk("perf_loads", 32'(perf_loads), 32'(n_loads));
    chk("perf_stores", 32'(perf_stores), 32'(n_stores));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
